// File: rtl/cordic_pkg.sv
// Angle scaling shared by the CORDIC modulator and angle detector.
// All angles are unsigned degrees in Q16.16.
package cordic_pkg;

  localparam int ATAN_N = 20;
  localparam int DEG_90  = 90  << 16;
  localparam int DEG_180 = 180 << 16;
  localparam int DEG_360 = 360 << 16;
  // 1/K for the CORDIC gain, Q0.16.
  localparam int KINV    = 39797;

  // atan(2^-k) in degrees, Q16.16, rounded to nearest.
  localparam int ATAN_DEG [ATAN_N] = '{
    2949120, 1740967, 919879, 466945, 234379, 117304, 58666, 29335,
    14668,   7334,    3667,   1833,   917,    458,    229,   115,
    57,      29,      14,     7
  };

  // Fold-stage decisions carried alongside the data to the fix-up stage.
  typedef struct packed {
    logic r_neg;
    logic i_neg;
    logic y_zero;
  } quad_t;

endpackage

// File: rtl/cordic_angle_det_if.sv
// Sample-in / polar-out stream with valid/ready handshake on both sides.
interface cordic_angle_det_if #(
  parameter int DW = 32
);
  logic          vld_i;
  logic          rdy_o;
  logic [DW-1:0] r_signal_i;
  logic [DW-1:0] i_signal_i;
  logic          vld_o;
  logic          rdy_i;
  logic [DW-1:0] theta_o;
  logic [DW-1:0] mag_o;

  modport slave (
    input  vld_i, r_signal_i, i_signal_i, rdy_i,
    output rdy_o, vld_o, theta_o, mag_o
  );

  modport master (
    output vld_i, r_signal_i, i_signal_i, rdy_i,
    input  rdy_o, vld_o, theta_o, mag_o
  );
endinterface

// File: rtl/cordic_angle_det_vec_stage.sv
// One registered vectoring micro-rotation: drives y toward zero and
// accumulates the applied rotation in z.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int DW    = 32,
  parameter int SHIFT = 0,
  parameter int ATAN  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 vld_i,
  input  logic signed [DW+1:0] x_i,
  input  logic signed [DW+1:0] y_i,
  input  logic signed [DW-1:0] z_i,
  input  quad_t                quad_i,
  output logic                 vld_o,
  output logic signed [DW+1:0] x_o,
  output logic signed [DW+1:0] y_o,
  output logic signed [DW-1:0] z_o,
  output quad_t                quad_o
);

  localparam logic signed [DW-1:0] ATAN_W = DW'(ATAN);

  logic signed [DW+1:0] x_d, y_d;
  logic signed [DW-1:0] z_d;
  logic signed [DW+1:0] x_q, y_q;
  logic signed [DW-1:0] z_q;
  quad_t                quad_q;
  logic                 vld_q;

  always_comb begin
    if (!y_i[DW+1]) begin
      x_d = x_i + (y_i >>> SHIFT);
      y_d = y_i - (x_i >>> SHIFT);
      z_d = z_i + ATAN_W;
    end else begin
      x_d = x_i - (y_i >>> SHIFT);
      y_d = y_i + (x_i >>> SHIFT);
      z_d = z_i - ATAN_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else if (en_i) begin
      vld_q <= vld_i;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      quad_q <= quad_i;
    end
  end

  assign vld_o  = vld_q;
  assign x_o    = x_q;
  assign y_o    = y_q;
  assign z_o    = z_q;
  assign quad_o = quad_q;

endmodule

// File: rtl/cordic_angle_det.sv
// Vectoring-mode CORDIC: complex sample in, phase (degrees) and gain-corrected
// magnitude out. Fully pipelined, one sample per clock, global-stall backpressure.
module cordic_angle_det
  import cordic_pkg::*;
#(
  parameter int ITER = 16,
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  cordic_angle_det_if.slave  bus
);

  localparam int XW = DW + 2;
  localparam logic signed [DW-1:0] D90  = DW'(DEG_90);
  localparam logic signed [DW-1:0] D180 = DW'(DEG_180);
  localparam logic signed [DW-1:0] D360 = DW'(DEG_360);

  function automatic logic signed [XW-1:0] abs_sat(input logic signed [DW-1:0] v);
    logic [DW-1:0] a;
    if (v == {1'b1, {(DW-1){1'b0}}}) a = {1'b0, {(DW-1){1'b1}}};
    else if (v[DW-1])                a = -v;
    else                             a = v;
    return {2'b00, a};
  endfunction

  function automatic logic [DW-1:0] mag_scale(input logic signed [XW-1:0] x);
    logic signed [XW+17:0] prod;
    logic        [XW+17:0] sh;
    prod = (XW+18)'(x) * (XW+18)'(KINV);
    sh   = prod >>> FRAC;
    if (x[XW-1])           return '0;
    else if (|sh[XW+17:DW]) return '1;
    else                   return sh[DW-1:0];
  endfunction

  // A nonzero imaginary part keeps a >= 1 LSB so a tiny negative i can never
  // wrap the result to exactly 360 (and then to 0).
  function automatic logic [DW-1:0] fix_theta(input logic signed [DW-1:0] z, input quad_t q);
    logic signed [DW-1:0] a, t;
    if (q.y_zero)                     a = '0;
    else if (z[DW-1] || z == '0)      a = {{(DW-1){1'b0}}, 1'b1};
    else if (z > D90)                 a = D90;
    else                              a = z;
    unique case ({q.r_neg, q.i_neg})
      2'b00:   t = a;
      2'b10:   t = D180 - a;
      2'b11:   t = D180 + a;
      default: t = D360 - a;
    endcase
    if (t == D360) t = '0;
    return t;
  endfunction

  logic en;

  logic                 vld_p0_q;
  logic signed [XW-1:0] x_p0_q, y_p0_q;
  quad_t                quad_p0_q;

  logic                 vld_s  [ITER+1];
  logic signed [XW-1:0] x_s    [ITER+1];
  logic signed [XW-1:0] y_s    [ITER+1];
  logic signed [DW-1:0] z_s    [ITER+1];
  quad_t                quad_s [ITER+1];

  logic          vld_o_q;
  logic [DW-1:0] theta_q, mag_q;

  assign en        = ~vld_o_q | bus.rdy_i;
  assign bus.rdy_o = en;

  // ---- p0: fold into the first quadrant ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
    end else if (en) begin
      vld_p0_q <= bus.vld_i;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x_p0_q    <= abs_sat($signed(bus.r_signal_i));
      y_p0_q    <= abs_sat($signed(bus.i_signal_i));
      quad_p0_q <= '{r_neg:  bus.r_signal_i[DW-1],
                     i_neg:  bus.i_signal_i[DW-1],
                     y_zero: (bus.i_signal_i == '0)};
    end
  end

  assign vld_s[0]  = vld_p0_q;
  assign x_s[0]    = x_p0_q;
  assign y_s[0]    = y_p0_q;
  assign z_s[0]    = '0;
  assign quad_s[0] = quad_p0_q;

  // ---- p1..pITER: micro-rotations ----
  for (genvar k = 0; k < ITER; k++) begin : g_rot
    cordic_vec_stage #(
      .DW    (DW),
      .SHIFT (k),
      .ATAN  (ATAN_DEG[k])
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .vld_i  (vld_s[k]),
      .x_i    (x_s[k]),
      .y_i    (y_s[k]),
      .z_i    (z_s[k]),
      .quad_i (quad_s[k]),
      .vld_o  (vld_s[k+1]),
      .x_o    (x_s[k+1]),
      .y_o    (y_s[k+1]),
      .z_o    (z_s[k+1]),
      .quad_o (quad_s[k+1])
    );
  end

  // ---- fix-up: unfold quadrant, remove gain ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o_q <= 1'b0;
      theta_q <= '0;
      mag_q   <= '0;
    end else if (en) begin
      vld_o_q <= vld_s[ITER];
      theta_q <= fix_theta(z_s[ITER], quad_s[ITER]);
      mag_q   <= mag_scale(x_s[ITER]);
    end
  end

  assign bus.vld_o   = vld_o_q;
  assign bus.theta_o = theta_q;
  assign bus.mag_o   = mag_q;

endmodule
